// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer (preamble/SFD, pad, CRC-32 FCS, IFG); stats ports under GMII_TX_STATS_EN
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG          = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy
`ifdef GMII_TX_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] underrun_count
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAD   = 3'd3;
    localparam logic [2:0] ST_FCS   = 3'd4;
    localparam logic [2:0] ST_UNDR  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;
    localparam logic [2:0] ST_IFG   = 3'd7;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] MIN_C    = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [31:0] crc;
    logic [15:0] cnt_inc;
    logic [31:0] fcs;

    // Reflected IEEE 802.3 CRC-32, one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // The byte count only needs to reach MIN_FRAME, so it sticks there for long frames.
    assign cnt_inc = (cnt == MIN_C) ? cnt : cnt + 16'd1;
    assign fcs     = ~crc;
    assign busy    = (state != ST_IDLE);

    // Frame sequencer; every GMII output is a register updated here. The SFD cycle is the
    // first DATA cycle: in_ready is already up so the first byte lands right behind 0xD5.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            crc      <= 32'hFFFFFFFF;
            txd      <= 8'h00;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            tx_er <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_PRE;
                        txd   <= 8'h55;
                        tx_en <= 1'b1;
                        cnt   <= '0;
                        crc   <= 32'hFFFFFFFF;
                    end
                end
                ST_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state    <= ST_DATA;
                        txd      <= 8'hD5;
                        in_ready <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        txd <= 8'h55;
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (in_valid) begin
                        txd <= in_data;
                        crc <= crc_byte(crc, in_data);
                        cnt <= cnt_inc;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            if (cnt_inc < MIN_C) begin
                                state <= ST_PAD;
                            end else begin
                                state <= ST_FCS;
                                cnt   <= '0;
                            end
                        end
                    end else begin
                        txd      <= 8'h00;
                        tx_er    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= ST_UNDR;
                    end
                end
                ST_PAD: begin
                    txd <= 8'h00;
                    crc <= crc_byte(crc, 8'h00);
                    if (cnt_inc == MIN_C) begin
                        state <= ST_FCS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_FCS: begin
                    txd <= fcs[{cnt[1:0], 3'b000} +: 8];
                    if (cnt[1:0] == 2'd3) begin
                        state <= ST_IFG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_UNDR: begin
                    txd      <= 8'h00;
                    tx_en    <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (in_valid && in_last) begin
                        in_ready <= 1'b0;
                        state    <= ST_IFG;
                        cnt      <= '0;
                    end
                end
                ST_IFG: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (cnt == IFG_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GMII_TX_STATS_EN
    // Completed-frame and underrun tallies; both wrap at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count    <= '0;
            underrun_count <= '0;
        end else begin
            if (state == ST_FCS && cnt[1:0] == 2'd3) begin
                frame_count <= frame_count + 16'd1;
            end
            if (state == ST_DATA && !in_valid) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - directed self-checking bench for gmii_tx_framer
module tb_gmii_tx_framer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;
    logic       busy;
`ifdef GMII_TX_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] underrun_count;
`endif

    always #4 clk = ~clk;

    gmii_tx_framer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .txd            (txd),
        .tx_en          (tx_en),
        .tx_er          (tx_er),
        .busy           (busy)
`ifdef GMII_TX_STATS_EN
        ,
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
`endif
    );

    typedef struct {
        int len;
        int seed;
        int exp_txen;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int   er_cnt    = 0;
    int   er_no_en  = 0;
    int   gap_cnt   = 0;
    int   last_gap  = -1;
    logic prev_en   = 1'b0;

    // Line monitor: captures every tx_en byte and measures idle gaps between bursts.
    always @(negedge clk) begin
        if (tx_en) begin
            cap_q.push_back(txd);
            if (!prev_en && gap_cnt > 0) last_gap = gap_cnt;
            gap_cnt = 0;
        end else if (prev_en || gap_cnt > 0) begin
            gap_cnt++;
        end
        if (tx_er) begin
            er_cnt++;
            if (!tx_en) er_no_en++;
        end
        prev_en = tx_en;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'((seed * 29 + i * 13 + ((i * i) >> 2)) & 255);
    endfunction

    // Bit-serial reference CRC: one LFSR step per data bit, LSB first.
    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic add_expected(input int len, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < len; i++) begin
            b = pat(seed, i);
            exp_q.push_back(b);
            c = crc_add(c, b);
        end
        for (int i = len; i < 60; i++) begin
            exp_q.push_back(8'h00);
            c = crc_add(c, 8'h00);
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[31:24]);
    endtask

    task automatic clear_mon();
        cap_q.delete();
        exp_q.delete();
        er_cnt   = 0;
        er_no_en = 0;
        gap_cnt  = 0;
        last_gap = -1;
    endtask

    // Handshake-driven source; stall_after >= 0 withdraws in_valid for two cycles after that many bytes.
    task automatic send_frame(input int len, input int seed, input int stall_after);
        int   idx;
        int   guard;
        logic hs;
        bit   stalled;
        idx = 0;
        guard = 0;
        stalled = 0;
        while (idx < len && guard < 5000) begin
            if (!stalled && idx == stall_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                stalled = 1;
            end
            in_valid = 1'b1;
            in_data  = pat(seed, idx);
            in_last  = (idx == len - 1);
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_accepted_bytes", 64'(idx), 64'(len));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic compare_capture(input string name);
        int bad;
        bad = 0;
        check({name, " txen_len"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i]) bad++;
        end
        check({name, " bad_bytes"}, 64'(bad), 64'd0);
    endtask

    // Running the CRC over payload+FCS must land on the IEEE residue.
    task automatic check_residue(input string name);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < cap_q.size(); i++) c = crc_add(c, cap_q[i]);
        check({name, " fcs_residue"}, 64'(c), 64'hDEBB20E3);
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{42, 1, 72};
        vecs[1] = '{98, 2, 110};
        vecs[2] = '{1, 3, 72};
        vecs[3] = '{59, 4, 72};
        vecs[4] = '{60, 5, 72};
        vecs[5] = '{61, 6, 73};

        #1 reset = 1'b0;
        #2;
        check("reset txd", 64'(txd), 64'd0);
        check("reset tx_en", 64'(tx_en), 64'd0);
        check("reset tx_er", 64'(tx_er), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle stays idle", 64'(busy | tx_en | in_ready), 64'd0);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            add_expected(vecs[v].len, vecs[v].seed);
            send_frame(vecs[v].len, vecs[v].seed, -1);
            wait_idle();
            check($sformatf("vec%0d txen_cycles", v), 64'(cap_q.size()), 64'(vecs[v].exp_txen));
            compare_capture($sformatf("vec%0d", v));
            check_residue($sformatf("vec%0d", v));
            check($sformatf("vec%0d tx_er_count", v), 64'(er_cnt), 64'd0);
        end

        // Back-to-back: second frame pending while the first finishes.
        clear_mon();
        add_expected(30, 7);
        add_expected(64, 8);
        send_frame(30, 7, -1);
        send_frame(64, 8, -1);
        wait_idle();
        compare_capture("b2b");
        check("b2b ifg_gap", 64'(last_gap), 64'd12);

        // Underrun after 20 of 60 bytes.
        clear_mon();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pat(9, i));
        exp_q.push_back(8'h00);
        send_frame(60, 9, 20);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("underrun ifg_cycles", 64'(n), 64'd12);
        compare_capture("underrun");
        check("underrun tx_er_count", 64'(er_cnt), 64'd1);
        check("underrun tx_er_without_en", 64'(er_no_en), 64'd0);
`ifdef GMII_TX_STATS_EN
        check("stats frame_count", 64'(frame_count), 64'd8);
        check("stats underrun_count", 64'(underrun_count), 64'd1);
`endif

        // Reset pulsed while padding a 10-byte frame.
        clear_mon();
        send_frame(10, 11, -1);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset tx_en", 64'(tx_en), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset tx_en", 64'(tx_en), 64'd0);
        check("mid_reset busy", 64'(busy), 64'd0);
        check("mid_reset txd", 64'(txd), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        add_expected(42, 12);
        send_frame(42, 12, -1);
        wait_idle();
        compare_capture("post_reset");
        check_residue("post_reset");
`ifdef GMII_TX_STATS_EN
        check("stats post_reset frame_count", 64'(frame_count), 64'd1);
        check("stats post_reset underrun_count", 64'(underrun_count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
